// File: rtl/led_rx_defs.sv
// Shared types and constants for the LED stream receiver.
package led_rx_defs;

  localparam int WORD_BITS = 24;
  localparam int INDEX_W   = 16;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [INDEX_W-1:0]   index;
    logic [WORD_BITS-1:0] color;
    logic                 on;
  } led_event_t;

endpackage

// File: rtl/led_rx_bit_decoder.sv
// Line synchronizer, edge detect, saturating high/low counters and the line-level FSM.
// Emits registered one-cycle pulses: decoded bit, latch gap, stuck-high abort.
//
// state | meaning
// SYNC  | after reset or abort; waiting for a full latch gap before trusting the line
// LOW   | line low inside a frame (or idle after a gap); a rise starts a bit
// HIGH  | line high; the fall ends a bit, an over-long high aborts to SYNC
module led_rx_bit_decoder
  import led_rx_defs::*;
#(
  parameter int T1H_MIN_CYCLES  = 30,
  parameter int HIGH_MAX_CYCLES = 100,
  parameter int RESET_CYCLES    = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic led_in,
  output logic bit_valid,
  output logic bit_value,
  output logic gap_detected,
  output logic stuck_high
);

  localparam int CNT_MAX = (RESET_CYCLES > HIGH_MAX_CYCLES) ? RESET_CYCLES : HIGH_MAX_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] T1H_MIN  = CNT_W'(T1H_MIN_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_MAX = CNT_W'(HIGH_MAX_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(RESET_CYCLES);

  logic             sync1, sync2, line_dly;
  logic             rise, fall;
  logic [CNT_W-1:0] low_cnt, high_cnt, low_nxt, high_nxt;
  logic             gap_hit, stuck_hit;
  rx_state_t        state, state_nxt;
  logic             bit_valid_nxt, gap_nxt, stuck_nxt;

  assign rise = sync2 & ~line_dly;
  assign fall = ~sync2 & line_dly;

  // Counters saturate at all-ones, which is at least CNT_MAX, so they never wrap.
  always_comb begin
    low_nxt  = low_cnt;
    high_nxt = high_cnt;
    if (sync2) begin
      low_nxt = '0;
      if (rise) high_nxt = CNT_W'(1);
      else if (high_cnt != '1) high_nxt = high_cnt + CNT_W'(1);
    end else if (low_cnt != '1) begin
      low_nxt = low_cnt + CNT_W'(1);
    end
  end

  assign gap_hit   = !sync2 && (low_nxt == GAP_LEN) && (low_cnt != GAP_LEN);
  assign stuck_hit = sync2 && (high_nxt == HIGH_MAX) && (high_cnt != HIGH_MAX);

  always_comb begin
    state_nxt     = state;
    bit_valid_nxt = 1'b0;
    gap_nxt       = 1'b0;
    stuck_nxt     = 1'b0;
    unique case (state)
      SYNC: begin
        if (gap_hit) begin
          state_nxt = LOW;
          gap_nxt   = 1'b1;
        end
      end
      LOW: begin
        if (rise) state_nxt = HIGH;
        else if (gap_hit) gap_nxt = 1'b1;
      end
      HIGH: begin
        if (fall) begin
          bit_valid_nxt = 1'b1;
          state_nxt     = LOW;
        end else if (stuck_hit) begin
          stuck_nxt = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      line_dly     <= 1'b0;
      low_cnt      <= '0;
      high_cnt     <= '0;
      state        <= SYNC;
      bit_valid    <= 1'b0;
      bit_value    <= 1'b0;
      gap_detected <= 1'b0;
      stuck_high   <= 1'b0;
    end else begin
      sync1        <= led_in;
      sync2        <= sync1;
      line_dly     <= sync2;
      low_cnt      <= low_nxt;
      high_cnt     <= high_nxt;
      state        <= state_nxt;
      bit_valid    <= bit_valid_nxt;
      gap_detected <= gap_nxt;
      stuck_high   <= stuck_nxt;
      if (bit_valid_nxt) bit_value <= (high_cnt >= T1H_MIN);
    end
  end

endmodule

// File: rtl/led_stream_receiver.sv
// LED strip stream receiver: assembles 24-bit words, indexes them per frame, reports frame status.
// Optional LED_RX_COLOR_CHECK_EN: led_on means exactly LED_COLOR, and unknown colours flag a frame error.
module led_stream_receiver
  import led_rx_defs::*;
#(
  parameter int          ARRAY_LENGTH    = 400,
  parameter logic [23:0] LED_COLOR       = 24'h00ff00,
  parameter int          T1H_MIN_CYCLES  = 30,
  parameter int          HIGH_MAX_CYCLES = 100,
  parameter int          RESET_CYCLES    = 2500
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              led_in,
  output logic                              led_valid,
  output logic [$clog2(ARRAY_LENGTH)-1:0]   led_index,
  output logic [23:0]                       led_color,
  output logic                              led_on,
  output logic                              frame_done,
  output logic [$clog2(ARRAY_LENGTH+1)-1:0] frame_len,
  output logic                              frame_error
);

  localparam int LED_IDX_W = $clog2(ARRAY_LENGTH);
  localparam int LEN_W     = $clog2(ARRAY_LENGTH + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(ARRAY_LENGTH);
  localparam logic [4:0]       LAST_BIT = 5'(WORD_BITS - 1);

  logic                 bit_valid, bit_value, gap_detected, stuck_high;
  logic [WORD_BITS-1:0] shift_q, word_nxt;
  logic [4:0]           bit_cnt;
  logic [LEN_W-1:0]     index;
  logic                 err_q, bit_seen;
  logic                 word_done, word_on, color_bad;
  led_event_t           evt;
  logic                 unused_bits;

  led_rx_bit_decoder #(
    .T1H_MIN_CYCLES (T1H_MIN_CYCLES),
    .HIGH_MAX_CYCLES(HIGH_MAX_CYCLES),
    .RESET_CYCLES   (RESET_CYCLES)
  ) u_bit_decoder (
    .clk         (clk),
    .rst         (rst),
    .led_in      (led_in),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .gap_detected(gap_detected),
    .stuck_high  (stuck_high)
  );

  assign word_nxt  = {shift_q[WORD_BITS-2:0], bit_value};
  assign word_done = bit_valid && (bit_cnt == LAST_BIT);

`ifdef LED_RX_COLOR_CHECK_EN
  assign word_on     = (word_nxt == LED_COLOR);
  assign color_bad   = !word_on && (word_nxt != '0);
  assign unused_bits = |evt.index[INDEX_W-1:LED_IDX_W];
`else
  assign word_on     = |word_nxt;
  assign color_bad   = 1'b0;
  assign unused_bits = |{evt.index[INDEX_W-1:LED_IDX_W], LED_COLOR};
`endif

  assign led_index = evt.index[LED_IDX_W-1:0];
  assign led_color = evt.color;
  assign led_on    = evt.on;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      index       <= '0;
      err_q       <= 1'b0;
      bit_seen    <= 1'b0;
      evt         <= '0;
      led_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      frame_error <= 1'b0;
    end else begin
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (stuck_high) begin
        frame_done  <= 1'b1;
        frame_len   <= index;
        frame_error <= 1'b1;
        bit_cnt     <= '0;
        index       <= '0;
        err_q       <= 1'b0;
        bit_seen    <= 1'b0;
      end else if (gap_detected) begin
        // A gap with no bits since the last one (idle line, or leaving SYNC) stays silent.
        if (bit_seen) begin
          frame_done  <= 1'b1;
          frame_len   <= index;
          frame_error <= err_q || (bit_cnt != '0);
        end
        bit_cnt  <= '0;
        index    <= '0;
        err_q    <= 1'b0;
        bit_seen <= 1'b0;
      end else if (bit_valid) begin
        shift_q  <= word_nxt;
        bit_seen <= 1'b1;
        if (word_done) begin
          bit_cnt <= '0;
          if (color_bad) err_q <= 1'b1;
          if (index < LEN_MAX) begin
            led_valid <= 1'b1;
            evt.index <= INDEX_W'(index);
            evt.color <= word_nxt;
            evt.on    <= word_on;
            index     <= index + LEN_W'(1);
          end else begin
            err_q <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_stream_receiver.sv
// Self-checking bench for led_stream_receiver: scoreboard of expected word/frame events
// checked by a monitor as the DUT pulses led_valid / frame_done.
module tb_led_stream_receiver;

  localparam int ARRAY_LENGTH = 4;
  localparam int RESET_CYCLES = 2500;
  localparam int IDX_W        = $clog2(ARRAY_LENGTH);
  localparam int LEN_W        = $clog2(ARRAY_LENGTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             led_in = 1'b0;
  logic             led_valid;
  logic [IDX_W-1:0] led_index;
  logic [23:0]      led_color;
  logic             led_on;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             frame_error;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit          is_frame;
    int          idx;
    logic [23:0] color;
    bit          on;
    int          len;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  led_stream_receiver #(
    .ARRAY_LENGTH   (ARRAY_LENGTH),
    .LED_COLOR      (24'h00ff00),
    .T1H_MIN_CYCLES (30),
    .HIGH_MAX_CYCLES(100),
    .RESET_CYCLES   (RESET_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .led_valid  (led_valid),
    .led_index  (led_index),
    .led_color  (led_color),
    .led_on     (led_on),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  function automatic bit exp_on(input logic [23:0] w);
`ifdef LED_RX_COLOR_CHECK_EN
    return w == 24'h00ff00;
`else
    return |w;
`endif
  endfunction

  function automatic bit exp_bad(input logic [23:0] w);
`ifdef LED_RX_COLOR_CHECK_EN
    return !(w == 24'h00ff00 || w == 24'h000000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_led(input int idx, input logic [23:0] w);
    exp_t e;
    e.is_frame = 1'b0; e.idx = idx; e.color = w; e.on = exp_on(w); e.len = 0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int len, input bit err);
    exp_t e;
    e.is_frame = 1'b1; e.idx = 0; e.color = '0; e.on = 1'b0; e.len = len; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (led_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0 || exp_q[0].is_frame) begin
        tests_failed++;
        $display("FAIL unexpected_led_valid: index=%0d color=%06h, required no word event", led_index, led_color);
      end else begin
        mon_e = exp_q.pop_front();
        if (led_index !== IDX_W'(mon_e.idx) || led_color !== mon_e.color || led_on !== mon_e.on) begin
          tests_failed++;
          $display("FAIL led_event: index=%0d color=%06h on=%0b, required index=%0d color=%06h on=%0b",
                   led_index, led_color, led_on, mon_e.idx, mon_e.color, mon_e.on);
        end
      end
    end
    if (frame_done === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0 || !exp_q[0].is_frame) begin
        tests_failed++;
        $display("FAIL unexpected_frame_done: len=%0d err=%0b, required no frame event", frame_len, frame_error);
      end else begin
        mon_e = exp_q.pop_front();
        if (frame_len !== LEN_W'(mon_e.len) || frame_error !== mon_e.err) begin
          tests_failed++;
          $display("FAIL frame_event: len=%0d err=%0b, required len=%0d err=%0b",
                   frame_len, frame_error, mon_e.len, mon_e.err);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_pulse(input int hi, input int lo);
    led_in = 1'b1;
    repeat (hi) @(negedge clk);
    led_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_pulse(w[i] ? 40 : 10, 10);
  endtask

  task automatic send_gap();
    led_in = 1'b0;
    repeat (RESET_CYCLES + 20) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({led_valid, led_index, led_color, led_on, frame_done, frame_len, frame_error} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: valid=%0b idx=%0d color=%06h on=%0b done=%0b len=%0d err=%0b, required all 0",
               led_valid, led_index, led_color, led_on, frame_done, frame_len, frame_error);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    send_gap();
    push_led(0, 24'h00ff00);
    push_led(1, 24'h000000);
    push_led(2, 24'h00ff00);
    send_word(24'h00ff00);
    send_word(24'h000000);
    send_word(24'h00ff00);
    push_frame(3, 1'b0);
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL basic_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pulse_width();
    logic [23:0] w;
    int lat;
    w = 24'ha5c30f;
    push_led(0, w);
    for (int i = 23; i >= 1; i--) send_pulse(w[i] ? 30 : 29, 6);
    led_in = 1'b1;
    repeat (w[0] ? 30 : 29) @(negedge clk);
    led_in = 1'b0;
    lat = 0;
    while (led_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL word_latency: %0d cycles, required 4", lat);
    end
    repeat (6) @(negedge clk);
    w = 24'h00ff00;
    push_led(1, w);
    for (int i = 23; i >= 0; i--) send_pulse(w[i] ? 30 : 4, 2);
    push_frame(2, exp_bad(24'ha5c30f));
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL pulse_width_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_partial_word();
    push_led(0, 24'h00ff00);
    send_word(24'h00ff00);
    for (int i = 0; i < 16; i++) send_pulse((i % 3 == 0) ? 40 : 10, 10);
    push_frame(1, 1'b1);
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL partial_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    logic [23:0] w;
    for (int k = 0; k < 6; k++) begin
      w = (k % 2 == 0) ? 24'h00ff00 : 24'h000000;
      if (k < ARRAY_LENGTH) push_led(k, w);
      send_word(w);
    end
    push_frame(ARRAY_LENGTH, 1'b1);
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL overflow_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stuck_high();
    push_frame(0, 1'b1);
    led_in = 1'b1;
    repeat (120) @(negedge clk);
    led_in = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL stuck_abort: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    send_word(24'h00ff00);
    send_gap();
    push_led(0, 24'h00ff00);
    send_word(24'h00ff00);
    push_frame(1, 1'b0);
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL stuck_recover_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 12; i++) send_pulse((i % 2 == 0) ? 40 : 10, 10);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({led_valid, led_index, led_color, led_on, frame_done, frame_len, frame_error} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_values: idx=%0d color=%06h on=%0b len=%0d err=%0b, required all 0",
               led_index, led_color, led_on, frame_len, frame_error);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_pulse(40, 10);
    send_gap();
    push_led(0, 24'h123456);
    send_word(24'h123456);
    push_frame(1, exp_bad(24'h123456));
    send_gap();
    wait_drain(100);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_drain: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_pulse_width();
    test_partial_word();
    test_overflow();
    test_stuck_high();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
